// File: rtl/uart_rx_controller_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_controller_if: receiver, control and host-read signals of the RX controller
// Rev 1.0
// ----------------------------------------------------------------------------
interface uart_rx_controller_if #(
   parameter int ADDR_W = 3
);
   logic              enable;
   logic              auto_baud;
   logic [2:0]        baud_init;
   logic              rx_done;
   logic [7:0]        rx_data;
   logic              rx_ferror;
   logic              rx_perror;
   logic              rx_en;
   logic [2:0]        baud_select;
   logic              rd_en;
   logic              clr_status;
   logic [7:0]        rd_data;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   count;
   logic              overrun;
   logic [7:0]        err_count;
   logic              baud_locked;

   modport master (
      output enable, auto_baud, baud_init, rx_done, rx_data, rx_ferror, rx_perror,
             rd_en, clr_status,
      input  rx_en, baud_select, rd_data, empty, full, count, overrun, err_count,
             baud_locked
   );

   modport slave (
      input  enable, auto_baud, baud_init, rx_done, rx_data, rx_ferror, rx_perror,
             rd_en, clr_status,
      output rx_en, baud_select, rd_data, empty, full, count, overrun, err_count,
             baud_locked
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_controller: receiver enable/auto-baud sequencing, RX FIFO and error stats
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_rx_controller #(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 3,
   parameter int ERR_LIMIT  = 4,
   parameter int SETTLE     = 16
) (
   input  wire logic          clk,
   input  wire logic          rst,
   uart_rx_controller_if.slave io_bus
);

   typedef enum logic [1:0] {
      S_OFF    = 2'd0,
      S_LISTEN = 2'd1,
      S_RETUNE = 2'd2
   } state_t;

   localparam logic [3:0]      c_ERR_LIMIT   = 4'(ERR_LIMIT);
   localparam logic [7:0]      c_SETTLE_LAST = 8'(SETTLE - 1);
   localparam logic [ADDR_W:0] c_DEPTH       = (ADDR_W + 1)'(FIFO_DEPTH);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_rx_en;
   logic [2:0]        r_baud;
   logic              r_locked;
   logic [3:0]        r_cerr;
   logic [7:0]        r_settle;
   logic [7:0]        r_mem [FIFO_DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic [7:0]        r_rd_data;
   logic              r_empty;
   logic              r_full;
   logic              r_overrun;
   logic [7:0]        r_err_count;

   logic              w_eval;
   logic              w_good;
   logic              w_bad;
   logic              w_pop;
   logic              w_wr;
   logic              w_drop;
   logic              w_enter_listen;
   logic              w_enter_retune;
   logic [3:0]        w_cerr_inc;
   logic [ADDR_W:0]   w_count_nxt;

   always_comb begin
      w_eval      = (r_state == S_LISTEN) && io_bus.enable && io_bus.rx_done;
      w_good      = w_eval && !io_bus.rx_ferror && !io_bus.rx_perror;
      w_bad       = w_eval && (io_bus.rx_ferror || io_bus.rx_perror);
      w_cerr_inc  = (r_cerr == 4'hF) ? r_cerr : r_cerr + 4'd1;
      w_pop       = io_bus.rd_en && !r_empty;
      // A full FIFO still accepts a byte when the same cycle frees a slot.
      w_wr        = w_good && (!r_full || w_pop);
      w_drop      = w_good && r_full && !w_pop;
      w_count_nxt = r_count + (ADDR_W + 1)'(w_wr) - (ADDR_W + 1)'(w_pop);
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!io_bus.enable) begin
         w_state_nxt = S_OFF;
      end else begin
         case (r_state)
            S_OFF:    w_state_nxt = S_LISTEN;
            S_LISTEN: if (w_bad && io_bus.auto_baud && !r_locked &&
                          (w_cerr_inc >= c_ERR_LIMIT))
                         w_state_nxt = S_RETUNE;
            S_RETUNE: if (r_settle == c_SETTLE_LAST)
                         w_state_nxt = S_LISTEN;
            default:  w_state_nxt = S_OFF;
         endcase
      end
      w_enter_listen = (r_state == S_OFF) && (w_state_nxt == S_LISTEN);
      w_enter_retune = (r_state == S_LISTEN) && (w_state_nxt == S_RETUNE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_OFF;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_en     <= 1'b0;
         r_baud      <= 3'd0;
         r_locked    <= 1'b0;
         r_cerr      <= 4'd0;
         r_settle    <= 8'd0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_rd_data   <= 8'd0;
         r_empty     <= 1'b1;
         r_full      <= 1'b0;
         r_overrun   <= 1'b0;
         r_err_count <= 8'd0;
      end else begin
         r_rx_en <= (w_state_nxt == S_LISTEN);

         if (w_enter_listen) begin
            r_baud   <= io_bus.baud_init;
            r_locked <= 1'b0;
            r_cerr   <= 4'd0;
         end else if (w_enter_retune) begin
            r_baud <= r_baud + 3'd1;
            r_cerr <= 4'd0;
         end else if (w_good) begin
            r_cerr   <= 4'd0;
            r_locked <= 1'b1;
         end else if (w_bad) begin
            r_cerr <= w_cerr_inc;
         end

         // Settle counter only advances while staying in RETUNE; zero elsewhere.
         if ((r_state == S_RETUNE) && (w_state_nxt == S_RETUNE))
            r_settle <= r_settle + 8'd1;
         else
            r_settle <= 8'd0;

         if (w_wr) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
            r_rd_data <= r_mem[r_rd_ptr];
         end
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == c_DEPTH);

         if (io_bus.clr_status) begin
            r_overrun   <= 1'b0;
            r_err_count <= 8'd0;
         end else begin
            if (w_drop) r_overrun <= 1'b1;
            if (w_bad && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= io_bus.rx_data;
   end

   assign io_bus.rx_en       = r_rx_en;
   assign io_bus.baud_select = r_baud;
   assign io_bus.baud_locked = r_locked;
   assign io_bus.rd_data     = r_rd_data;
   assign io_bus.empty       = r_empty;
   assign io_bus.full        = r_full;
   assign io_bus.count       = r_count;
   assign io_bus.overrun     = r_overrun;
   assign io_bus.err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_rx_controller: directed vector table plus sequences for auto-baud, FIFO and reset
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_rx_controller;
   localparam int FIFO_DEPTH = 8;
   localparam int ADDR_W     = 3;
   localparam int ERR_LIMIT  = 4;
   localparam int SETTLE     = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   uart_rx_controller_if #(.ADDR_W(ADDR_W)) bus ();

   uart_rx_controller #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .ADDR_W    (ADDR_W),
      .ERR_LIMIT (ERR_LIMIT),
      .SETTLE    (SETTLE)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .io_bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic [2:0] binit;
      logic       done;
      logic [7:0] data;
      logic       rd;
      logic       e_rx_en;
      logic [2:0] e_baud;
      logic       e_lock;
      logic [7:0] e_rd;
      logic [3:0] e_cnt;
      logic       e_empty;
   } vec_t;

   vec_t vt [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [7:0] d, input logic fe, input logic pe);
      bus.rx_done   = 1'b1;
      bus.rx_data   = d;
      bus.rx_ferror = fe;
      bus.rx_perror = pe;
      tick();
      bus.rx_done   = 1'b0;
      bus.rx_ferror = 1'b0;
      bus.rx_perror = 1'b0;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      bus.enable     = 1'b0;
      bus.auto_baud  = 1'b0;
      bus.baud_init  = 3'd0;
      bus.rx_done    = 1'b0;
      bus.rx_data    = 8'd0;
      bus.rx_ferror  = 1'b0;
      bus.rx_perror  = 1'b0;
      bus.rd_en      = 1'b0;
      bus.clr_status = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".rx_en"},       32'(bus.rx_en),       32'd0);
      check({tag, ".baud_select"}, 32'(bus.baud_select), 32'd0);
      check({tag, ".baud_locked"}, 32'(bus.baud_locked), 32'd0);
      check({tag, ".empty"},       32'(bus.empty),       32'd1);
      check({tag, ".full"},        32'(bus.full),        32'd0);
      check({tag, ".count"},       32'(bus.count),       32'd0);
      check({tag, ".rd_data"},     32'(bus.rd_data),     32'd0);
      check({tag, ".overrun"},     32'(bus.overrun),     32'd0);
      check({tag, ".err_count"},   32'(bus.err_count),   32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation timed out");
      $fatal(1, "watchdog");
   end

   initial begin
      int low;
      logic low_seen;
      logic [7:0] exp_b;

      vt[0] = '{1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 1'b1, 3'd3, 1'b0, 8'h00, 4'd0, 1'b1};
      vt[1] = '{1'b1, 3'd3, 1'b1, 8'h41, 1'b0, 1'b1, 3'd3, 1'b1, 8'h00, 4'd1, 1'b0};
      vt[2] = '{1'b1, 3'd3, 1'b1, 8'h42, 1'b0, 1'b1, 3'd3, 1'b1, 8'h00, 4'd2, 1'b0};
      vt[3] = '{1'b1, 3'd3, 1'b1, 8'h43, 1'b0, 1'b1, 3'd3, 1'b1, 8'h00, 4'd3, 1'b0};
      vt[4] = '{1'b1, 3'd3, 1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 1'b1, 8'h41, 4'd2, 1'b0};
      vt[5] = '{1'b1, 3'd3, 1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 1'b1, 8'h42, 4'd1, 1'b0};
      vt[6] = '{1'b1, 3'd3, 1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 1'b1, 8'h43, 4'd0, 1'b1};
      vt[7] = '{1'b1, 3'd3, 1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 1'b1, 8'h43, 4'd0, 1'b1};
      vt[8] = '{1'b1, 3'd3, 1'b1, 8'h44, 1'b1, 1'b1, 3'd3, 1'b1, 8'h43, 4'd1, 1'b0};
      vt[9] = '{1'b1, 3'd3, 1'b0, 8'h00, 1'b1, 1'b1, 3'd3, 1'b1, 8'h44, 4'd0, 1'b1};

      do_reset();
      check_reset_outputs("reset");

      // Basic receive and read-back, driven from the vector table.
      for (int i = 0; i < 10; i++) begin
         bus.enable    = vt[i].en;
         bus.baud_init = vt[i].binit;
         bus.rx_done   = vt[i].done;
         bus.rx_data   = vt[i].data;
         bus.rd_en     = vt[i].rd;
         tick();
         check($sformatf("vec%0d.rx_en", i),       32'(bus.rx_en),       32'(vt[i].e_rx_en));
         check($sformatf("vec%0d.baud_select", i), 32'(bus.baud_select), 32'(vt[i].e_baud));
         check($sformatf("vec%0d.baud_locked", i), 32'(bus.baud_locked), 32'(vt[i].e_lock));
         check($sformatf("vec%0d.rd_data", i),     32'(bus.rd_data),     32'(vt[i].e_rd));
         check($sformatf("vec%0d.count", i),       32'(bus.count),       32'(vt[i].e_cnt));
         check($sformatf("vec%0d.empty", i),       32'(bus.empty),       32'(vt[i].e_empty));
         check($sformatf("vec%0d.full", i),        32'(bus.full),        32'd0);
      end
      bus.rx_done = 1'b0;
      bus.rd_en   = 1'b0;

      // Auto-baud: four parity errors from baud 7 step to baud 0.
      do_reset();
      bus.enable    = 1'b1;
      bus.auto_baud = 1'b1;
      bus.baud_init = 3'd7;
      tick();
      check("ab.start_baud", 32'(bus.baud_select), 32'd7);
      for (int i = 0; i < 4; i++) begin
         frame(8'hE0 + 8'(i), 1'b0, 1'b1);
         if (i == 2) begin
            check("ab.third_rx_en", 32'(bus.rx_en),       32'd1);
            check("ab.third_baud",  32'(bus.baud_select), 32'd7);
         end
      end
      check("ab.err_count",   32'(bus.err_count),   32'd4);
      check("ab.retune_rxen", 32'(bus.rx_en),       32'd0);
      check("ab.wrap_baud",   32'(bus.baud_select), 32'd0);
      low = 1;
      frame(8'h55, 1'b0, 1'b0);
      check("ab.retune_ignore_cnt",  32'(bus.count),       32'd0);
      check("ab.retune_ignore_lock", 32'(bus.baud_locked), 32'd0);
      if (!bus.rx_en) low++;
      for (int k = 0; k < 40 && bus.rx_en == 1'b0; k++) begin
         tick();
         if (!bus.rx_en) low++;
      end
      check("ab.low_cycles",   32'(low),       32'(SETTLE));
      check("ab.rx_en_return", 32'(bus.rx_en), 32'd1);
      frame(8'h5A, 1'b0, 1'b0);
      check("ab.locked", 32'(bus.baud_locked), 32'd1);
      check("ab.count",  32'(bus.count),       32'd1);
      check("ab.baud",   32'(bus.baud_select), 32'd0);

      // Locked: framing errors are counted but never move the baud rate.
      bus.clr_status = 1'b1;
      tick();
      bus.clr_status = 1'b0;
      check("lk.clr_err", 32'(bus.err_count), 32'd0);
      low_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         frame(8'hB0, 1'b1, 1'b0);
         if (!bus.rx_en) low_seen = 1'b1;
      end
      check("lk.baud",      32'(bus.baud_select), 32'd0);
      check("lk.err_count", 32'(bus.err_count),   32'd10);
      check("lk.count",     32'(bus.count),       32'd1);
      check("lk.rx_en_low", 32'(low_seen),        32'd0);
      check("lk.locked",    32'(bus.baud_locked), 32'd1);

      // FIFO fill, overrun, push+pop at full, clear priority, ordered drain.
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      check("ff.pop5a", 32'(bus.rd_data), 32'h5A);
      check("ff.cnt0",  32'(bus.count),   32'd0);
      for (int i = 0; i < 8; i++) frame(8'h10 + 8'(i), 1'b0, 1'b0);
      check("ff.full",     32'(bus.full),    32'd1);
      check("ff.count8",   32'(bus.count),   32'd8);
      check("ff.no_ovr",   32'(bus.overrun), 32'd0);
      frame(8'h18, 1'b0, 1'b0);
      check("ff.overrun",  32'(bus.overrun), 32'd1);
      check("ff.count9th", 32'(bus.count),   32'd8);
      bus.clr_status = 1'b1;
      frame(8'hFF, 1'b1, 1'b0);
      bus.clr_status = 1'b0;
      check("ff.clr_ovr", 32'(bus.overrun),   32'd0);
      check("ff.clr_err", 32'(bus.err_count), 32'd0);
      bus.rd_en = 1'b1;
      frame(8'h19, 1'b0, 1'b0);
      bus.rd_en = 1'b0;
      check("ff.pp_count",   32'(bus.count),   32'd8);
      check("ff.pp_overrun", 32'(bus.overrun), 32'd0);
      check("ff.pp_rd",      32'(bus.rd_data), 32'h10);
      check("ff.pp_full",    32'(bus.full),    32'd1);
      for (int i = 0; i < 8; i++) begin
         bus.rd_en = 1'b1;
         tick();
         bus.rd_en = 1'b0;
         exp_b = (i < 7) ? 8'h11 + 8'(i) : 8'h19;
         check($sformatf("ff.drain%0d", i), 32'(bus.rd_data), 32'(exp_b));
      end
      check("ff.drain_empty", 32'(bus.empty), 32'd1);
      check("ff.drain_count", 32'(bus.count), 32'd0);

      // Error counter saturation with auto-baud off.
      bus.auto_baud = 1'b0;
      for (int i = 0; i < 300; i++) begin
         frame(8'h00, 1'b1, 1'b0);
         if (i == 253) check("sat.err254", 32'(bus.err_count), 32'd254);
         if (i == 254) check("sat.err255", 32'(bus.err_count), 32'd255);
      end
      check("sat.err300", 32'(bus.err_count), 32'd255);

      // Asynchronous reset while retuning with buffered bytes.
      do_reset();
      bus.enable    = 1'b1;
      bus.auto_baud = 1'b1;
      bus.baud_init = 3'd2;
      tick();
      for (int i = 0; i < 5; i++) frame(8'h20 + 8'(i), 1'b0, 1'b0);
      bus.enable = 1'b0;
      tick();
      check("rr.off_rx_en", 32'(bus.rx_en), 32'd0);
      check("rr.off_count", 32'(bus.count), 32'd5);
      bus.enable = 1'b1;
      tick();
      check("rr.relock_clear", 32'(bus.baud_locked), 32'd0);
      check("rr.rx_en",        32'(bus.rx_en),       32'd1);
      for (int i = 0; i < 4; i++) frame(8'hEE, 1'b0, 1'b1);
      check("rr.retune_rx_en", 32'(bus.rx_en),       32'd0);
      check("rr.retune_baud",  32'(bus.baud_select), 32'd3);
      tick();
      tick();
      tick();
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("rr.async");
      tick();
      bus.enable = 1'b0;
      rst = 1'b0;
      tick();
      check("rr.post_count", 32'(bus.count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
